// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared types and constants for the instruction sequencer.
//               Contents: FSM state encoding, opcode and ALU operation codes,
//               control strobe bundle and its state decoder, and the default
//               handshake timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

  // FSM states, 4-bit encoding (also exported on the debug `state` port)
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAULT = 4'd8
  } state_t;

  // Opcodes taken from IR[31:27]
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;

  // ALU operation codes; ALU_OR must stay 3 to match the existing ALU
  localparam int ALU_ADD = 1;
  localparam int ALU_SUB = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_AND = 4;

  localparam int WAIT_MAX_DEFAULT = 64;

  // DataPath control strobes driven by the sequencer
  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_out;
    logic r_in;
    logic ba_out;
    logic ry_in;
    logic imm_out;
    logic rz_in;
    logic rzlo_out;
  } ctrl_t;

  // Strobe set for a given state; imm_form selects the T4 operand source.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic imm_form);
    ctrl_t c;
    c = '0;
    case (s)
      ST_T0: c.inc_pc = 1'b1;
      ST_T1: begin
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.read   = 1'b1;
        c.mdr_in = 1'b1;
      end
      ST_T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      ST_T3: begin
        c.grb    = 1'b1;
        c.ba_out = 1'b1;
        c.r_out  = 1'b1;
        c.ry_in  = 1'b1;
      end
      ST_T4: begin
        c.rz_in = 1'b1;
        if (imm_form) begin
          c.imm_out = 1'b1;
        end else begin
          c.grc   = 1'b1;
          c.r_out = 1'b1;
        end
      end
      ST_T5: begin
        c.rzlo_out = 1'b1;
        c.gra      = 1'b1;
        c.r_in     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Combinational opcode decoder.
//               opcode   in  [4:0]     IR[31:27]
//               valid    out           opcode is supported
//               imm_form out           immediate-form (operand from Immout)
//               alu_op   out [OPW-1:0] ALU operation select
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
  import instr_sequencer_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [4:0]     opcode,
  output logic           valid,
  output logic           imm_form,
  output logic [OPW-1:0] alu_op
);

  always_comb begin
    valid    = 1'b1;
    imm_form = 1'b0;
    alu_op   = '0;
    case (opcode)
      OP_ADD:  alu_op = OPW'(ALU_ADD);
      OP_SUB:  alu_op = OPW'(ALU_SUB);
      OP_AND:  alu_op = OPW'(ALU_AND);
      OP_OR:   alu_op = OPW'(ALU_OR);
      OP_ADDI: begin alu_op = OPW'(ALU_ADD); imm_form = 1'b1; end
      OP_ANDI: begin alu_op = OPW'(ALU_AND); imm_form = 1'b1; end
      OP_ORI:  begin alu_op = OPW'(ALU_OR);  imm_form = 1'b1; end
      default: valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Control-step sequencer for register- and immediate-form ALU
//               instructions. Fetch T0-T2, execute T3-T5, with bounded
//               memFinished / finished handshake waits.
// Ports       : Clock, clear (async active-low), run, opcode[4:0],
//               memFinished, finished -> fetch/execute strobes, start,
//               opSelect[OPW-1:0], done, fault, state[3:0].
// Config      : INSTR_SEQUENCER_SINGLE_STEP_EN adds input `step`; non-wait
//               states advance only when step=1 and the wait timeout counts
//               only on step cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic           run,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic           step,
`endif
  input  logic [4:0]     opcode,
  input  logic           memFinished,
  input  logic           finished,
  output logic           PCout,
  output logic           IncPC,
  output logic           MARin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rout,
  output logic           Rin,
  output logic           BAout,
  output logic           RYin,
  output logic           Immout,
  output logic           RZin,
  output logic           RZLOout,
  output logic           start,
  output logic [OPW-1:0] opSelect,
  output logic           done,
  output logic           fault,
  output logic [3:0]     state
);

  localparam int c_CNT_W = $clog2(WAIT_MAX);

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [c_CNT_W-1:0] w_wait_cnt_nxt;
  logic               w_timeout;
  logic               w_step;

  logic               w_dec_valid;
  logic               w_dec_imm;
  logic [OPW-1:0]     w_dec_op;
  logic               r_imm_form;
  logic [OPW-1:0]     r_alu_op;
  logic               w_imm_sel;
  logic [OPW-1:0]     w_op_sel;

  ctrl_t              w_ctrl;
  logic               w_start;
  logic               w_done;
  logic [OPW-1:0]     w_op_out;

  ctrl_t              r_ctrl;
  logic               r_start;
  logic               r_done;
  logic               r_fault;
  logic [OPW-1:0]     r_op_sel;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif

  instr_decode #(.OPW(OPW)) u_decode (
    .opcode   (opcode),
    .valid    (w_dec_valid),
    .imm_form (w_dec_imm),
    .alu_op   (w_dec_op)
  );

  // Last held cycle allowed before a missing handshake becomes a fault.
  assign w_timeout = (r_wait_cnt == c_CNT_W'(WAIT_MAX - 1));

  // On the T3->T4 transition the live decode is used; afterwards the
  // captured copy keeps T4/T5 stable even if opcode changes.
  assign w_imm_sel = (r_state == ST_T3) ? w_dec_imm : r_imm_form;
  assign w_op_sel  = (r_state == ST_T3) ? w_dec_op  : r_alu_op;

  // Next state and next (to-be-registered) outputs
  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      ST_IDLE: if (run && w_step) w_next = ST_T0;
      ST_T0: if (w_step) begin
        w_next         = ST_T1;
        w_wait_cnt_nxt = '0;
      end
      ST_T1: begin
        if (memFinished) begin
          w_next = ST_T2;
        end else if (w_step) begin
          if (w_timeout) w_next = ST_FAULT;
          else           w_wait_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
        end
      end
      ST_T2: if (w_step) w_next = ST_T3;
      ST_T3: if (w_step) begin
        if (w_dec_valid) begin
          w_next         = ST_T4;
          w_wait_cnt_nxt = '0;
        end else begin
          w_next = ST_FAULT;
        end
      end
      ST_T4: begin
        // finished is ignored during the start-pulse cycle
        if (!r_start && finished) begin
          w_next = ST_T5;
        end else if (w_step) begin
          if (w_timeout) w_next = ST_FAULT;
          else           w_wait_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
        end
      end
      ST_T5: if (w_step) w_next = ST_DONE;
      ST_DONE: if (w_step) w_next = run ? ST_T0 : ST_IDLE;
      ST_FAULT: w_next = ST_FAULT;
      default: w_next = ST_FAULT;
    endcase

    w_ctrl   = ctrl_decode(w_next, w_imm_sel);
    w_start  = (w_next == ST_T4) && (r_state != ST_T4);
    w_done   = (w_next == ST_DONE);
    w_op_out = ((w_next == ST_T4) || (w_next == ST_T5)) ? w_op_sel : '0;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_imm_form <= 1'b0;
      r_alu_op   <= '0;
      r_ctrl     <= '0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_op_sel   <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (r_state == ST_T3) begin
        r_imm_form <= w_dec_imm;
        r_alu_op   <= w_dec_op;
      end
      r_ctrl     <= w_ctrl;
      r_start    <= w_start;
      r_done     <= w_done;
      r_fault    <= r_fault | (w_next == ST_FAULT);
      r_op_sel   <= w_op_out;
    end
  end

  assign PCout    = r_ctrl.pc_out;
  assign IncPC    = r_ctrl.inc_pc;
  assign MARin    = r_ctrl.mar_in;
  assign Read     = r_ctrl.read;
  assign MDRin    = r_ctrl.mdr_in;
  assign MDRout   = r_ctrl.mdr_out;
  assign IRin     = r_ctrl.ir_in;
  assign Gra      = r_ctrl.gra;
  assign Grb      = r_ctrl.grb;
  assign Grc      = r_ctrl.grc;
  assign Rout     = r_ctrl.r_out;
  assign Rin      = r_ctrl.r_in;
  assign BAout    = r_ctrl.ba_out;
  assign RYin     = r_ctrl.ry_in;
  assign Immout   = r_ctrl.imm_out;
  assign RZin     = r_ctrl.rz_in;
  assign RZLOout  = r_ctrl.rzlo_out;
  assign start    = r_start;
  assign opSelect = r_op_sel;
  assign done     = r_done;
  assign fault    = r_fault;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised control-step sequencer that replaces hand-timed per-instruction control sequences with a reusable FSM. It drives the DataPath control strobes through fetch (T0–T2) and execute (T3–T5) for register-form and immediate-form ALU instructions. Memory and ALU completion are handled with `memFinished`/`finished` handshakes and a bounded wait, not fixed delays. It sits between the instruction register opcode field and the DataPath control inputs.

## Interface
- `OPW`, 6: width of `opSelect`.
- `WAIT_MAX`, 64: maximum cycles spent waiting on any one handshake before faulting (≥2).
- `Clock` input 1: single system clock, rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `run` input 1: level; start and continue instruction execution.
- `opcode` input 5: IR[31:27], sampled in T3.
- `memFinished`, `finished` inputs 1 each: memory read complete, ALU operation complete.
- `PCout`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin` outputs 1 each: fetch strobes.
- `Gra`, `Grb`, `Grc`, `Rout`, `Rin`, `BAout`, `RYin`, `Immout`, `RZin`, `RZLOout` outputs 1 each: execute strobes.
- `start` output 1: one-cycle ALU start pulse.
- `opSelect` output OPW: ALU operation.
- `done` output 1: one-cycle pulse on instruction retire.
- `fault` output 1: sticky; timeout or illegal opcode.
- `state` output 4: current FSM state, for debug.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, DONE, FAULT.
- IDLE → T0 when `run`=1.
- T0: `IncPC`.
- T1: `PCout`, `MARin`, `Read`, `MDRin`. Held until `memFinished`=1, then → T2.
- T2: `MDRout`, `IRin`.
- T3: `Grb`, `BAout`, `Rout`, `RYin`. Decode `opcode`. Illegal opcode → FAULT.
- T4, register form: `Grc`, `Rout`, `RZin`. Immediate form: `Immout`, `RZin`. `opSelect` = decoded op. Held until `finished`=1, then → T5.
- T5: `RZLOout`, `Gra`, `Rin`.
- DONE: `done` pulses for one cycle. Next state T0 if `run`=1, else IDLE.
- FAULT: all strobes 0, `fault`=1. Left only by `clear`.
- Supported opcodes: add 3, sub 4, and 5, or 6 (register form); addi 12, andi 13, ori 14 (immediate form). All others are illegal.
- Wait counter: cleared on entry to T1/T4, increments each held cycle. Reaching WAIT_MAX without the handshake → FAULT.
- Deasserting `run` mid-instruction has no effect; the instruction completes and the FSM goes to IDLE from DONE.

## Timing
- Every output is registered and decoded from the state entered. Strobes are valid for the whole cycle the FSM occupies that state.
- `start` is high only in the first T4 cycle. `finished` is ignored in that first cycle and sampled from the second T4 cycle on.
- `memFinished` is sampled from the first T1 cycle on.
- Minimum latency: `run` high to `done` = 8 cycles (T0, T1, T2, T3, T4×2, T5, DONE).
- Reset (`clear`=0, asynchronous): state IDLE, every output 0, `opSelect`=0, wait counter 0, `fault`=0. Reset mid-wait aborts immediately with no partial `Rin`.
- `opSelect` holds its value from T4 through T5 and returns to 0 in DONE.

## Configuration
- `INSTR_SEQUENCER_SINGLE_STEP_EN` defined: adds input `step` (1 bit). Each non-wait state advances only on a cycle with `step`=1. Handshake waits still require their handshake, and the timeout counts only while `step`=1.
- Macro undefined: the `step` port is absent and the FSM free-runs as above.

## Structure
- Package `instr_sequencer_pkg` holds:
  - the state enumeration (4-bit encodings);
  - opcode constants;
  - ALU op constants, with `ALU_OR`=3 matching the existing ALU;
  - the default for `WAIT_MAX`.
- Sub-module `instr_decode` (combinational): opcode → {`valid`, `imm_form`, `alu_op`}. It is instantiated once and used in T3/T4.

## Test plan
- ori R3,R4,0x55 with R4=0x2AA; `memFinished` after 3 T1 cycles; `finished` after 2 → `opSelect`=3 and `Immout`=1 in T4, `Rin` and `Gra` in T5, R3=0x2FF, `done` at cycle 10.
- add (opcode 3): `Grc`/`Rout` asserted in T4, `Immout`=0, `start` exactly one cycle wide.
- `memFinished` held 0 → `fault`=1 after WAIT_MAX=64 T1 cycles, all strobes 0, state FAULT until `clear`.
- Opcode 31 → FAULT directly from T3; no `RZin`, no `start`.
- `clear` pulsed low during T4 → every output 0 in the same cycle, IDLE afterward. `run`=1 then restarts at T0.
- `run` held high for two instructions → DONE goes directly to T0, with two `done` pulses 8 cycles apart at minimum latency.
